// File: rtl/upc_sequencer.sv
// upc_sequencer: micro-program counter with jump, conditional, multiway branch and call/return stack
module upc_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int N_TGT       = 16,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_ADDR  = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [2:0]              op,
    input  logic                    cond,
    input  logic [ADDR_W-1:0]       jmp_addr,
    input  logic [N_TGT-1:0]        sel,
    input  logic [N_TGT*ADDR_W-1:0] tgt_table,
    input  logic                    clr_err,
    output logic [ADDR_W-1:0]       upc,
    output logic                    stk_empty,
    output logic                    stk_full,
    output logic                    nomatch,
    output logic                    err_ovf,
    output logic                    err_unf
);
    localparam int PW = $clog2(STACK_DEPTH + 1);
    localparam int IW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
    logic [ADDR_W-1:0] stk [STACK_DEPTH];
    logic [PW-1:0]     ptr, ptr_d;
    logic [ADDR_W-1:0] upc_d, inc, mbr_tgt, top;
    logic              mbr_hit, push, ovf, unf, nm;
    assign inc       = ADDR_W'(upc + 1'b1);
    assign stk_empty = ptr == '0;
    assign stk_full  = ptr == PW'(STACK_DEPTH);
    assign top       = stk[IW'(ptr - 1'b1)];
    always_comb begin
        mbr_hit = 1'b0;
        mbr_tgt = '0;
        for (int i = N_TGT - 1; i >= 0; i--)
            if (sel[i]) begin
                mbr_hit = 1'b1;
                mbr_tgt = tgt_table[i*ADDR_W +: ADDR_W];
            end
    end
    always_comb begin
        upc_d = upc;
        ptr_d = ptr;
        push  = 1'b0;
        ovf   = 1'b0;
        unf   = 1'b0;
        nm    = 1'b0;
        case (op)
            3'd0: upc_d = inc;
            3'd1: upc_d = jmp_addr;
            3'd2: upc_d = cond ? jmp_addr : inc;
            3'd3: begin
                upc_d = mbr_hit ? mbr_tgt : inc;
                nm    = !mbr_hit;
            end
            3'd4: begin
                upc_d = stk_full ? inc : jmp_addr;
                ovf   = stk_full;
                push  = !stk_full;
                ptr_d = stk_full ? ptr : PW'(ptr + 1'b1);
            end
            3'd5: begin
                upc_d = stk_empty ? inc : top;
                unf   = stk_empty;
                ptr_d = stk_empty ? ptr : PW'(ptr - 1'b1);
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            upc     <= ADDR_W'(RESET_ADDR);
            ptr     <= '0;
            nomatch <= 1'b0;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else if (en) begin
            upc     <= upc_d;
            ptr     <= ptr_d;
            nomatch <= nm;
            err_ovf <= ovf | (err_ovf & ~clr_err);
            err_unf <= unf | (err_unf & ~clr_err);
        end else begin
            nomatch <= 1'b0;
        end
    always_ff @(posedge clk)
        if (en && push) stk[IW'(ptr)] <= inc;
endmodule

// File: tb/tb_upc_sequencer.sv
// tb_upc_sequencer: directed checks of sequencing ops, stack, error flags and reset
module tb_upc_sequencer;
    logic         clk = 1'b0;
    logic         rst_n, en, cond, clr_err;
    logic [2:0]   op;
    logic [7:0]   jmp_addr;
    logic [15:0]  sel;
    logic [127:0] tgt_table;
    logic [7:0]   upc;
    logic         stk_empty, stk_full, nomatch, err_ovf, err_unf;
    int           total = 0;
    int           bad = 0;

    upc_sequencer #(.ADDR_W(8), .N_TGT(16), .STACK_DEPTH(4), .RESET_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .op(op), .cond(cond), .jmp_addr(jmp_addr),
        .sel(sel), .tgt_table(tgt_table), .clr_err(clr_err), .upc(upc),
        .stk_empty(stk_empty), .stk_full(stk_full), .nomatch(nomatch),
        .err_ovf(err_ovf), .err_unf(err_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [2:0] o, input logic [7:0] a);
        op = o;
        jmp_addr = a;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; cond = 1'b0; clr_err = 1'b0;
        op = 3'd0; jmp_addr = 8'h00; sel = 16'h0;
        for (int i = 0; i < 16; i++) tgt_table[i*8 +: 8] = 8'h80 + 8'(i);
        tgt_table[3*8 +: 8] = 8'h11;
        tgt_table[5*8 +: 8] = 8'h29;
        #3;
        chk("rst_upc", upc, 0);
        chk("rst_empty", stk_empty, 1);
        chk("rst_full", stk_full, 0);
        chk("rst_nomatch", nomatch, 0);
        chk("rst_ovf", err_ovf, 0);
        chk("rst_unf", err_unf, 0);
        #9;
        rst_n = 1'b1;
        en = 1'b1;
        step(3'd0, 8'h00); chk("next1", upc, 8'h01);
        step(3'd0, 8'h00); chk("next2", upc, 8'h02);
        step(3'd0, 8'h00); chk("next3", upc, 8'h03);
        step(3'd1, 8'hFF); chk("jmp_ff", upc, 8'hFF);
        step(3'd0, 8'h00); chk("wrap", upc, 8'h00);
        sel = 16'h0028;
        step(3'd3, 8'h00); chk("mbr_low", upc, 8'h11);
        chk("mbr_hit_nm", nomatch, 0);
        sel = 16'h0000;
        step(3'd3, 8'h00); chk("mbr_none", upc, 8'h12);
        chk("nm_pulse", nomatch, 1);
        step(3'd6, 8'h77); chk("hold_upc", upc, 8'h12);
        chk("nm_drop", nomatch, 0);
        sel = 16'h8000;
        step(3'd3, 8'h00); chk("mbr_top", upc, 8'h8F);
        sel = 16'h0000;
        cond = 1'b0;
        step(3'd2, 8'h55); chk("jmpc_0", upc, 8'h90);
        cond = 1'b1;
        step(3'd2, 8'h10); chk("jmpc_1", upc, 8'h10);
        cond = 1'b0;
        step(3'd4, 8'h40); chk("call1", upc, 8'h40);
        chk("call1_empty", stk_empty, 0);
        step(3'd4, 8'h50); chk("call2", upc, 8'h50);
        step(3'd5, 8'h00); chk("ret1", upc, 8'h41);
        step(3'd5, 8'h00); chk("ret2", upc, 8'h11);
        chk("ret2_empty", stk_empty, 1);
        step(3'd4, 8'h20); chk("fill1", upc, 8'h20);
        step(3'd4, 8'h30); chk("fill2", upc, 8'h30);
        step(3'd4, 8'h40); chk("fill3", upc, 8'h40);
        chk("fill3_full", stk_full, 0);
        step(3'd4, 8'h50); chk("fill4", upc, 8'h50);
        chk("fill4_full", stk_full, 1);
        clr_err = 1'b1;
        step(3'd4, 8'h60); chk("ovf_upc", upc, 8'h51);
        chk("ovf_flag", err_ovf, 1);
        chk("ovf_full", stk_full, 1);
        step(3'd7, 8'h00); chk("clr_ovf", err_ovf, 0);
        chk("clr_hold", upc, 8'h51);
        clr_err = 1'b0;
        step(3'd5, 8'h00); chk("pop4", upc, 8'h41);
        step(3'd5, 8'h00); chk("pop3", upc, 8'h31);
        step(3'd5, 8'h00); chk("pop2", upc, 8'h21);
        step(3'd5, 8'h00); chk("pop1", upc, 8'h12);
        chk("pop_empty", stk_empty, 1);
        step(3'd5, 8'h00); chk("unf_upc", upc, 8'h13);
        chk("unf_flag", err_unf, 1);
        chk("unf_empty", stk_empty, 1);
        en = 1'b0;
        clr_err = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(3'd1, 8'hAA);
            chk("frz_upc", upc, 8'h13);
        end
        chk("frz_unf", err_unf, 1);
        en = 1'b1;
        clr_err = 1'b0;
        step(3'd3, 8'h00); chk("nm2_upc", upc, 8'h14);
        chk("nm2_pulse", nomatch, 1);
        en = 1'b0;
        step(3'd3, 8'h00); chk("nm2_frz", nomatch, 0);
        chk("nm2_frz_upc", upc, 8'h14);
        en = 1'b1;
        clr_err = 1'b1;
        step(3'd6, 8'h00); chk("clr_unf", err_unf, 0);
        clr_err = 1'b0;
        step(3'd4, 8'h70); chk("mid_call1", upc, 8'h70);
        step(3'd4, 8'h80); chk("mid_call2", upc, 8'h80);
        #2 rst_n = 1'b0;
        #2;
        chk("mid_rst_upc", upc, 0);
        chk("mid_rst_empty", stk_empty, 1);
        chk("mid_rst_full", stk_full, 0);
        #2 rst_n = 1'b1;
        step(3'd0, 8'h00); chk("post_rst", upc, 8'h01);
        step(3'd5, 8'h00); chk("post_ret", upc, 8'h02);
        chk("post_unf", err_unf, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
